// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the xfft frame sequencer.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        CFG,
        FILL,
        DRAIN,
        DONE
    } state_t;

    // Cycles the core is held in reset before configuration.
    localparam int CORE_RST_CYC = 2;

    // Forward transform.
    localparam logic [7:0] CFG_WORD_DEF = 8'h01;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Core-facing AXI-stream channels and learn-RAM write port of the frame sequencer.
interface fft_frame_ctrl_if #(
    parameter int NFFT_LOG2 = 12,
    parameter int DW        = 24
);
    logic                 fft_aresetn;
    logic                 cfg_tvalid;
    logic [7:0]           cfg_tdata;
    logic                 cfg_tready;
    logic                 s_tvalid;
    logic                 s_tlast;
    logic                 s_tready;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic [DW-1:0]        m_re;
    logic [DW-1:0]        m_im;
    logic                 wr_en;
    logic [NFFT_LOG2-1:0] wr_addr;
    logic [DW-1:0]        wr_real;
    logic [DW-1:0]        wr_imag;

    modport master (
        output fft_aresetn,
        output cfg_tvalid, cfg_tdata,
        input  cfg_tready,
        output s_tvalid, s_tlast,
        input  s_tready,
        input  m_tvalid, m_tlast, m_re, m_im,
        output wr_en, wr_addr, wr_real, wr_imag
    );

    modport slave (
        input  fft_aresetn,
        input  cfg_tvalid, cfg_tdata,
        output cfg_tready,
        input  s_tvalid, s_tlast,
        output s_tready,
        output m_tvalid, m_tlast, m_re, m_im,
        input  wr_en, wr_addr, wr_real, wr_imag
    );

endinterface

// File: rtl/fft_peak_track.sv
// Running maximum of |re| + |im| over forwarded bins; result published on load.
module fft_peak_track #(
    parameter int NFFT_LOG2 = 12,
    parameter int DW        = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 valid,
    input  logic [NFFT_LOG2-1:0] bin,
    input  logic [DW-1:0]        re,
    input  logic [DW-1:0]        im,
    input  logic                 load,
    output logic [NFFT_LOG2-1:0] peak_bin,
    output logic [DW:0]          peak_mag
);

    logic [DW-1:0]        abs_re;
    logic [DW-1:0]        abs_im;
    logic [DW:0]          mag;
    logic [DW:0]          max_mag_reg;
    logic [NFFT_LOG2-1:0] max_bin_reg;
    logic                 seen_reg;
    logic [NFFT_LOG2-1:0] peak_bin_reg;
    logic [DW:0]          peak_mag_reg;

    // Negating the most negative value still fits as an unsigned DW-bit number.
    assign abs_re = re[DW-1] ? (~re + 1'b1) : re;
    assign abs_im = im[DW-1] ? (~im + 1'b1) : im;
    assign mag    = {1'b0, abs_re} + {1'b0, abs_im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_mag_reg  <= '0;
            max_bin_reg  <= '0;
            seen_reg     <= 1'b0;
            peak_bin_reg <= '0;
            peak_mag_reg <= '0;
        end else begin
            if (clr) begin
                max_mag_reg <= '0;
                max_bin_reg <= '0;
                seen_reg    <= 1'b0;
            end else if (valid && (!seen_reg || mag > max_mag_reg)) begin
                // Strict compare: equal magnitudes keep the earlier (lower) bin.
                max_mag_reg <= mag;
                max_bin_reg <= bin;
                seen_reg    <= 1'b1;
            end
            if (load) begin
                peak_bin_reg <= max_bin_reg;
                peak_mag_reg <= max_mag_reg;
            end
        end
    end

    assign peak_bin = peak_bin_reg;
    assign peak_mag = peak_mag_reg;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Single-shot / continuous frame sequencer around the xfft core with windowed bin forwarding.
// Define FFT_PEAK_EN to build the peak-magnitude tracker; otherwise peak_bin/peak_mag stay 0.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int         NFFT_LOG2 = 12,
    parameter int         DW        = 24,
    parameter int         BIN_LO    = 0,
    parameter int         BIN_HI    = 2799,
    parameter logic [7:0] CFG_WORD  = CFG_WORD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 abort,
    fft_frame_ctrl_if.master     bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_tlast,
    output logic [NFFT_LOG2-1:0] peak_bin,
    output logic [DW:0]          peak_mag
);

    localparam logic [NFFT_LOG2-1:0] LAST     = {NFFT_LOG2{1'b1}};
    localparam logic [NFFT_LOG2-1:0] LO       = NFFT_LOG2'(BIN_LO);
    localparam logic [NFFT_LOG2-1:0] HI       = NFFT_LOG2'(BIN_HI);
    localparam logic [1:0]           RST_LAST = 2'(CORE_RST_CYC - 1);

    state_t               state_reg, state_next;
    logic [1:0]           rst_cnt_reg, rst_cnt_next;
    logic [NFFT_LOG2-1:0] in_cnt_reg, in_cnt_next;
    logic [NFFT_LOG2-1:0] out_cnt_reg, out_cnt_next;

    logic                 fft_aresetn_reg;
    logic                 wr_en_reg;
    logic [NFFT_LOG2-1:0] wr_addr_reg;
    logic [DW-1:0]        wr_real_reg;
    logic [DW-1:0]        wr_imag_reg;
    logic                 err_tlast_reg;

    logic out_beat, last_bin, lo_ok, hi_ok, fwd_beat;

    assign out_beat = (state_reg == DRAIN) && bus.m_tvalid;
    assign last_bin = (out_cnt_reg == LAST);
    assign fwd_beat = out_beat && lo_ok && hi_ok && !abort;

    // Bounds at the edges of the counter range need no comparator.
    if (BIN_LO == 0) begin : g_lo_all
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (out_cnt_reg >= LO);
    end

    if (BIN_HI >= (1 << NFFT_LOG2) - 1) begin : g_hi_all
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = (out_cnt_reg <= HI);
    end

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = '0;
        in_cnt_next  = in_cnt_reg;
        out_cnt_next = out_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = CORE_RST;
            end
            CORE_RST: begin
                in_cnt_next  = '0;
                out_cnt_next = '0;
                if (rst_cnt_reg == RST_LAST) state_next = CFG;
                else                         rst_cnt_next = rst_cnt_reg + 2'd1;
            end
            CFG: begin
                if (bus.cfg_tready) state_next = FILL;
            end
            FILL: begin
                if (bus.s_tready) begin
                    in_cnt_next = in_cnt_reg + 1'b1;
                    if (in_cnt_reg == LAST) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.m_tvalid) begin
                    out_cnt_next = out_cnt_reg + 1'b1;
                    if (last_bin) state_next = DONE;
                end
            end
            DONE: begin
                state_next = continuous ? CORE_RST : IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a coincident start.
        if (abort) begin
            state_next   = IDLE;
            rst_cnt_next = '0;
            in_cnt_next  = '0;
            out_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            rst_cnt_reg     <= '0;
            in_cnt_reg      <= '0;
            out_cnt_reg     <= '0;
            fft_aresetn_reg <= 1'b0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_real_reg     <= '0;
            wr_imag_reg     <= '0;
            err_tlast_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rst_cnt_reg     <= rst_cnt_next;
            in_cnt_reg      <= in_cnt_next;
            out_cnt_reg     <= out_cnt_next;
            fft_aresetn_reg <= !(abort || state_next == CORE_RST);
            wr_en_reg       <= fwd_beat;
            err_tlast_reg   <= out_beat && !abort && (bus.m_tlast != last_bin);
            if (fwd_beat) begin
                wr_addr_reg <= out_cnt_reg - LO;
                wr_real_reg <= bus.m_re;
                wr_imag_reg <= bus.m_im;
            end
        end
    end

    assign bus.fft_aresetn = fft_aresetn_reg;
    assign bus.cfg_tvalid  = (state_reg == CFG);
    assign bus.cfg_tdata   = CFG_WORD;
    assign bus.s_tvalid    = (state_reg == FILL);
    assign bus.s_tlast     = (state_reg == FILL) && (in_cnt_reg == LAST);
    assign bus.wr_en       = wr_en_reg;
    assign bus.wr_addr     = wr_addr_reg;
    assign bus.wr_real     = wr_real_reg;
    assign bus.wr_imag     = wr_imag_reg;

    assign busy       = (state_reg != IDLE);
    assign frame_done = (state_reg == DONE) && !abort;
    assign err_tlast  = err_tlast_reg;

`ifdef FFT_PEAK_EN
    fft_peak_track #(
        .NFFT_LOG2 (NFFT_LOG2),
        .DW        (DW)
    ) u_peak (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_reg == CORE_RST),
        .valid    (fwd_beat),
        .bin      (out_cnt_reg),
        .re       (bus.m_re),
        .im       (bus.m_im),
        .load     (frame_done),
        .peak_bin (peak_bin),
        .peak_mag (peak_mag)
    );
`else
    assign peak_bin = '0;
    assign peak_mag = '0;
`endif

endmodule
